id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised instruction-decode pipeline stage that sits between IF and EX.
//  - Decodes the 16-opcode ISA into register addresses, shift amount and control/flag enables.
//  - Registers the decoded bundle into the ID/EX register under a valid/ready handshake.
//  - Detects load-use hazards and inserts bubbles.
//  - Honours flush from branch/jump resolution.
//  - Runs a halt FSM, so "pc==0 suppression" is replaced by explicit valid qualification.
// PARAMETERS
//  INSTR_W   16  instruction width; opcode is always instr[INSTR_W-1 -: 4]
//  PC_W      16  program-counter width, carried through to EX unchanged
//  RA_W      4   register-address width (2**RA_W registers); link register = all-ones
//  SHAMT_W   4   shift-amount width, taken from instr[SHAMT_W-1:0]
//  ADDZ_MASK 1   1: the if_dont_en input suppresses z_en for ADD; 0: input ignored
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        asynchronous active-low reset
//  if_valid    in   1        IF presents an instruction
//  if_instr    in   INSTR_W  instruction word
//  if_pc       in   PC_W     pc of the instruction
//  if_dont_en  in   1        ADD Z-flag suppress qualifier
//  id_ready    out  1        ID accepts the IF word this cycle
//  flush       in   1        kill the ID/EX contents and the incoming word
//  ex_ready    in   1        EX accepts the ID/EX bundle
//  ex_valid    out  1        ID/EX bundle valid
//  ex_pc       out  PC_W     registered pc
//  ex_func     out  4        registered opcode
//  ex_p0/ex_p1/ex_dst  out  RA_W  registered source/destination addresses
//  ex_shamt    out  SHAMT_W  registered shift amount (0 unless SLL/SRL/SRA)
//  ex_ctrl     out  18       {re0,re1,we,src1sel,cmplmt,jal,jr,b,memtoReg,mem_wt,mem_rd,lswj_sel,z_en,n_en,ov_en,hlt,cond[2:0]->pad}
//  stall       out  1        load-use hazard active this cycle
//  halted      out  1        a HLT has retired into EX; the core is stopped
// BEHAVIOUR
//  Reset: ex_valid=0; every ex_* field=0; state=RUN; halted=0; stall=0.
//  Decode (combinational, unchanged ISA):
//    - p0 = instr[11:8] for LHB, else instr[7:4].
//    - p1 = instr[11:8] for SW, else instr[3:0].
//    - dst = all-ones for JAL, else instr[11:8].
//    - re/we/enable tables per opcode, as in the ISA document.
//  Latency: one cycle from acceptance to the bundle appearing on ex_*.
//  Handshake:
//    - advance = ~ex_valid | ex_ready.
//    - id_ready = advance & ~stall & (state==RUN).
//    - Accept when if_valid & id_ready.
//  Hazard: stall = if_valid & ex_valid & ex_ctrl.mem_rd & (ex_dst!=0) & ((re0 & p0==ex_dst) | (re1 & p1==ex_dst)).
//    - On stall & advance: the ID/EX register loads a bubble (ex_valid=0).
//    - IF holds its word for the next cycle.
//  Empty cycle: advance & ~accept loads ex_valid=0; fields are don't-care but keep their old value.
//  ~advance: the ID/EX register holds all fields.
//  flush (highest priority):
//    - Next cycle ex_valid=0.
//    - An incoming word in the same cycle is dropped, even if accepted.
//    - id_ready is unaffected by flush.
//  Halt FSM:
//    - RUN -> HALT_PEND when a HLT is accepted without flush.
//    - HALT_PEND -> HALTED when ex_valid & ex_ready & ex_ctrl.hlt.
//    - HALT_PEND -> RUN on flush.
//    - HALTED is sticky until rst_n; halted = (state==HALTED).
//    - In HALT_PEND and HALTED, id_ready=0.
//  Reset asserted mid-operation clears the bundle immediately (asynchronous); no partial state survives.
//  Simultaneous flush and HALT_PEND->HALTED retire: the retire wins (the HLT was already consumed); state becomes HALTED.
// STRUCTURE
//  Shared package cpu_isa_pkg:
//    - Opcode localparams ADD..HLT.
//    - Branch condition codes NE..TRUE.
//    - ex_ctrl bit indices.
//    - Halt FSM state encoding.
//  Sub-module id_ctrl_dec: purely combinational instr -> {p0,p1,dst,shamt,ctrl}.
//  Top level: hazard logic, ID/EX register, halt FSM.
// TESTING
//  - ADD r3,r1,r2 (0x3312) valid, ex_ready=1 -> next cycle ex_valid=1, p0=1, p1=2, dst=3, re0=re1=we=z_en=n_en=ov_en=1.
//  - LW r4,[r5] then ADD r6,r4,r1 back-to-back -> stall=1 for one cycle, one bubble; ADD issues in cycle 3.
//  - ex_ready=0 for 3 cycles with a valid bundle -> ex_* stable, id_ready=0; releases on ex_ready=1.
//  - flush with if_valid=1 carrying JAL (0xD000) -> ex_valid=0 next cycle; the JAL is not issued.
//  - HLT (0xF000) accepted -> HALT_PEND, id_ready=0; retire -> halted=1.
//  - Flush while in HALT_PEND -> state returns to RUN.
//  - rst_n pulsed low mid-stream -> ex_valid=0 and halted=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | cpu_isa_pkg : opcodes, branch conditions, ex_ctrl bit map, halt FSM states
// | Revision 1.0
// +-----------------------------------------------------------------------------
package cpu_isa_pkg;

  localparam logic [3:0] OP_SUB  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_NOR  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_ADDZ = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Branch condition lives in the upper three bits of the dst field of a B.
  localparam logic [2:0] CC_NE   = 3'd0;
  localparam logic [2:0] CC_EQ   = 3'd1;
  localparam logic [2:0] CC_GT   = 3'd2;
  localparam logic [2:0] CC_LT   = 3'd3;
  localparam logic [2:0] CC_GTE  = 3'd4;
  localparam logic [2:0] CC_LTE  = 3'd5;
  localparam logic [2:0] CC_OVF  = 3'd6;
  localparam logic [2:0] CC_TRUE = 3'd7;

  localparam int CTRL_W        = 18;
  localparam int CTRL_RE0      = 17;
  localparam int CTRL_RE1      = 16;
  localparam int CTRL_WE       = 15;
  localparam int CTRL_SRC1SEL  = 14;
  localparam int CTRL_CMPLMT   = 13;
  localparam int CTRL_JAL      = 12;
  localparam int CTRL_JR       = 11;
  localparam int CTRL_B        = 10;
  localparam int CTRL_MEMTOREG = 9;
  localparam int CTRL_MEMWT    = 8;
  localparam int CTRL_MEMRD    = 7;
  localparam int CTRL_LSWJ     = 6;
  localparam int CTRL_ZEN      = 5;
  localparam int CTRL_NEN      = 4;
  localparam int CTRL_OVEN     = 3;
  localparam int CTRL_HLT      = 2;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } halt_state_e;

endpackage
`default_nettype wire

// File: rtl/id_ctrl_dec.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | id_ctrl_dec : combinational instruction decode to register fields and ctrl
// | Revision 1.0
// +-----------------------------------------------------------------------------
module id_ctrl_dec
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int RA_W      = 4,
  parameter int SHAMT_W   = 4,
  parameter int ADDZ_MASK = 1
) (
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_dont_en,
  output logic [3:0]         o_func,
  output logic [RA_W-1:0]    o_p0,
  output logic [RA_W-1:0]    o_p1,
  output logic [RA_W-1:0]    o_dst,
  output logic [SHAMT_W-1:0] o_shamt,
  output logic [CTRL_W-1:0]  o_ctrl
);

  logic [3:0]      w_op;
  logic [RA_W-1:0] w_f_hi;
  logic [RA_W-1:0] w_f_mid;
  logic [RA_W-1:0] w_f_lo;

  assign w_op    = i_instr[INSTR_W-1 -: 4];
  assign w_f_hi  = i_instr[3*RA_W-1 -: RA_W];
  assign w_f_mid = i_instr[2*RA_W-1 -: RA_W];
  assign w_f_lo  = i_instr[RA_W-1:0];

  assign o_func = w_op;
  assign o_p0   = (w_op == OP_LHB) ? w_f_hi : w_f_mid;
  assign o_p1   = (w_op == OP_SW)  ? w_f_hi : w_f_lo;
  assign o_dst  = (w_op == OP_JAL) ? {RA_W{1'b1}} : w_f_hi;

  always_comb begin
    o_ctrl  = '0;
    o_shamt = '0;
    case (w_op)
      OP_SUB: begin
        o_ctrl[CTRL_RE0] = 1'b1; o_ctrl[CTRL_RE1] = 1'b1; o_ctrl[CTRL_WE] = 1'b1;
        o_ctrl[CTRL_CMPLMT] = 1'b1;
        o_ctrl[CTRL_ZEN] = 1'b1; o_ctrl[CTRL_NEN] = 1'b1; o_ctrl[CTRL_OVEN] = 1'b1;
      end
      OP_AND, OP_NOR: begin
        o_ctrl[CTRL_RE0] = 1'b1; o_ctrl[CTRL_RE1] = 1'b1; o_ctrl[CTRL_WE] = 1'b1;
        o_ctrl[CTRL_ZEN] = 1'b1;
      end
      OP_ADD: begin
        o_ctrl[CTRL_RE0] = 1'b1; o_ctrl[CTRL_RE1] = 1'b1; o_ctrl[CTRL_WE] = 1'b1;
        o_ctrl[CTRL_ZEN] = ~((ADDZ_MASK != 0) & i_dont_en);
        o_ctrl[CTRL_NEN] = 1'b1; o_ctrl[CTRL_OVEN] = 1'b1;
      end
      OP_ADDZ: begin
        o_ctrl[CTRL_RE0] = 1'b1; o_ctrl[CTRL_RE1] = 1'b1; o_ctrl[CTRL_WE] = 1'b1;
        o_ctrl[CTRL_ZEN] = 1'b1; o_ctrl[CTRL_NEN] = 1'b1; o_ctrl[CTRL_OVEN] = 1'b1;
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        o_ctrl[CTRL_RE0] = 1'b1; o_ctrl[CTRL_WE] = 1'b1; o_ctrl[CTRL_ZEN] = 1'b1;
        o_shamt = i_instr[SHAMT_W-1:0];
      end
      OP_LW: begin
        o_ctrl[CTRL_RE0] = 1'b1; o_ctrl[CTRL_WE] = 1'b1; o_ctrl[CTRL_SRC1SEL] = 1'b1;
        o_ctrl[CTRL_MEMTOREG] = 1'b1; o_ctrl[CTRL_MEMRD] = 1'b1; o_ctrl[CTRL_LSWJ] = 1'b1;
      end
      OP_SW: begin
        o_ctrl[CTRL_RE0] = 1'b1; o_ctrl[CTRL_RE1] = 1'b1; o_ctrl[CTRL_SRC1SEL] = 1'b1;
        o_ctrl[CTRL_MEMWT] = 1'b1; o_ctrl[CTRL_LSWJ] = 1'b1;
      end
      // LHB reads its own destination so the low byte can be preserved.
      OP_LHB: begin
        o_ctrl[CTRL_RE0] = 1'b1; o_ctrl[CTRL_WE] = 1'b1; o_ctrl[CTRL_SRC1SEL] = 1'b1;
      end
      OP_LLB: begin
        o_ctrl[CTRL_WE] = 1'b1; o_ctrl[CTRL_SRC1SEL] = 1'b1;
      end
      OP_B:   o_ctrl[CTRL_B] = 1'b1;
      OP_JAL: begin
        o_ctrl[CTRL_JAL] = 1'b1; o_ctrl[CTRL_WE] = 1'b1; o_ctrl[CTRL_LSWJ] = 1'b1;
      end
      OP_JR: begin
        o_ctrl[CTRL_JR] = 1'b1; o_ctrl[CTRL_RE0] = 1'b1;
      end
      OP_HLT:  o_ctrl[CTRL_HLT] = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | id_stage_pipe : ID stage with ID/EX register, load-use hazard and halt FSM
// | Revision 1.0
// +-----------------------------------------------------------------------------
module id_stage_pipe
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int PC_W      = 16,
  parameter int RA_W      = 4,
  parameter int SHAMT_W   = 4,
  parameter int ADDZ_MASK = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [PC_W-1:0]    if_pc,
  input  logic               if_dont_en,
  output logic               id_ready,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [PC_W-1:0]    ex_pc,
  output logic [3:0]         ex_func,
  output logic [RA_W-1:0]    ex_p0,
  output logic [RA_W-1:0]    ex_p1,
  output logic [RA_W-1:0]    ex_dst,
  output logic [SHAMT_W-1:0] ex_shamt,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic               stall,
  output logic               halted
);

  logic [3:0]         w_func;
  logic [RA_W-1:0]    w_p0;
  logic [RA_W-1:0]    w_p1;
  logic [RA_W-1:0]    w_dst;
  logic [SHAMT_W-1:0] w_shamt;
  logic [CTRL_W-1:0]  w_ctrl;
  logic               w_advance;
  logic               w_stall;
  logic               w_ready;
  logic               w_accept;

  logic               r_valid;
  logic [PC_W-1:0]    r_pc;
  logic [3:0]         r_func;
  logic [RA_W-1:0]    r_p0;
  logic [RA_W-1:0]    r_p1;
  logic [RA_W-1:0]    r_dst;
  logic [SHAMT_W-1:0] r_shamt;
  logic [CTRL_W-1:0]  r_ctrl;
  halt_state_e        r_state;
  logic               r_halted;

  id_ctrl_dec #(
    .INSTR_W  (INSTR_W),
    .RA_W     (RA_W),
    .SHAMT_W  (SHAMT_W),
    .ADDZ_MASK(ADDZ_MASK)
  ) u_dec (
    .i_instr  (if_instr),
    .i_dont_en(if_dont_en),
    .o_func   (w_func),
    .o_p0     (w_p0),
    .o_p1     (w_p1),
    .o_dst    (w_dst),
    .o_shamt  (w_shamt),
    .o_ctrl   (w_ctrl)
  );

  assign w_advance = ~r_valid | ex_ready;
  assign w_stall   = if_valid & r_valid & r_ctrl[CTRL_MEMRD] & (r_dst != '0)
                   & ((w_ctrl[CTRL_RE0] & (w_p0 == r_dst)) | (w_ctrl[CTRL_RE1] & (w_p1 == r_dst)));
  assign w_ready   = w_advance & ~w_stall & (r_state == ST_RUN);
  assign w_accept  = if_valid & w_ready;

  // Fields are only loaded on an accepted word; bubbles and flushes clear valid alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_func  <= '0;
      r_p0    <= '0;
      r_p1    <= '0;
      r_dst   <= '0;
      r_shamt <= '0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_pc    <= if_pc;
        r_func  <= w_func;
        r_p0    <= w_p0;
        r_p1    <= w_p1;
        r_dst   <= w_dst;
        r_shamt <= w_shamt;
        r_ctrl  <= w_ctrl;
      end
    end
  end

  // A retiring HLT outranks a concurrent flush: the HLT has already left ID/EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept & ~flush & (w_func == OP_HLT))
            r_state <= ST_HALT_PEND;
        end
        ST_HALT_PEND: begin
          if (r_valid & ex_ready & r_ctrl[CTRL_HLT]) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (flush) begin
            r_state <= ST_RUN;
          end
        end
        ST_HALTED: r_halted <= 1'b1;
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign id_ready = w_ready;
  assign stall    = w_stall;
  assign halted   = r_halted;
  assign ex_valid = r_valid;
  assign ex_pc    = r_pc;
  assign ex_func  = r_func;
  assign ex_p0    = r_p0;
  assign ex_p1    = r_p1;
  assign ex_dst   = r_dst;
  assign ex_shamt = r_shamt;
  assign ex_ctrl  = r_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_id_stage_pipe : directed self-checking bench for id_stage_pipe
// | Revision 1.0
// +-----------------------------------------------------------------------------
module tb_id_stage_pipe;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_dont_en;
  logic        id_ready;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [15:0] ex_pc;
  logic [3:0]  ex_func;
  logic [3:0]  ex_p0;
  logic [3:0]  ex_p1;
  logic [3:0]  ex_dst;
  logic [3:0]  ex_shamt;
  logic [17:0] ex_ctrl;
  logic        stall;
  logic        halted;

  int total;
  int bad;

  id_stage_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_dont_en(if_dont_en),
    .id_ready  (id_ready),
    .flush     (flush),
    .ex_ready  (ex_ready),
    .ex_valid  (ex_valid),
    .ex_pc     (ex_pc),
    .ex_func   (ex_func),
    .ex_p0     (ex_p0),
    .ex_p1     (ex_p1),
    .ex_dst    (ex_dst),
    .ex_shamt  (ex_shamt),
    .ex_ctrl   (ex_ctrl),
    .stall     (stall),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    if_dont_en = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ex_valid); end
    total++; if (ex_ctrl !== 18'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", ex_ctrl); end
    total++; if (ex_pc !== 16'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", ex_pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    step(); step();
    rst_n = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", id_ready); end
  endtask

  task automatic test_add();
    if_valid = 1'b1; if_instr = 16'h3312; if_pc = 16'h0100;
    step();
    if_valid = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", ex_valid); end
    total++; if ({ex_func, ex_dst, ex_p0, ex_p1} !== 16'h3312) begin bad++; $display("FAIL add_fields got=%h want=3312", {ex_func, ex_dst, ex_p0, ex_p1}); end
    total++; if (ex_ctrl !== 18'h38038) begin bad++; $display("FAIL add_ctrl got=%h want=38038", ex_ctrl); end
    total++; if (ex_pc !== 16'h0100) begin bad++; $display("FAIL add_pc got=%h want=0100", ex_pc); end
    total++; if (ex_shamt !== 4'h0) begin bad++; $display("FAIL add_shamt got=%h want=0", ex_shamt); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%b want=0", ex_valid); end
    total++; if (ex_pc !== 16'h0100) begin bad++; $display("FAIL empty_hold_pc got=%h want=0100", ex_pc); end
  endtask

  task automatic test_add_dont_en();
    if_valid = 1'b1; if_instr = 16'h3312; if_pc = 16'h0110; if_dont_en = 1'b1;
    step();
    if_valid = 1'b0; if_dont_en = 1'b0;
    #1;
    total++; if (ex_ctrl !== 18'h38018) begin bad++; $display("FAIL add_dont_en_ctrl got=%h want=38018", ex_ctrl); end
    step();
  endtask

  task automatic test_shift();
    if_valid = 1'b1; if_instr = 16'h5275; if_pc = 16'h0120;
    step();
    if_valid = 1'b0;
    #1;
    total++; if ({ex_dst, ex_p0, ex_shamt} !== 12'h275) begin bad++; $display("FAIL sll_fields got=%h want=275", {ex_dst, ex_p0, ex_shamt}); end
    total++; if (ex_ctrl !== 18'h28020) begin bad++; $display("FAIL sll_ctrl got=%h want=28020", ex_ctrl); end
    step();
  endtask

  task automatic test_load_use();
    if_valid = 1'b1; if_instr = 16'h8450; if_pc = 16'h0200;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lw_nostall got=%b want=0", stall); end
    step();
    total++; if (ex_ctrl !== 18'h2C2C0) begin bad++; $display("FAIL lw_ctrl got=%h want=2c2c0", ex_ctrl); end
    if_instr = 16'h3641; if_pc = 16'h0202;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", stall); end
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL lu_ready got=%b want=0", id_ready); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b want=0", ex_valid); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_clear got=%b want=0", stall); end
    step();
    if_valid = 1'b0;
    #1;
    total++; if ({ex_valid, ex_pc, ex_dst} !== {1'b1, 16'h0202, 4'h6}) begin bad++; $display("FAIL lu_issue got=%b/%h/%h want=1/0202/6", ex_valid, ex_pc, ex_dst); end
    step();
  endtask

  task automatic test_backpressure();
    if_valid = 1'b1; if_instr = 16'h3312; if_pc = 16'h0300;
    step();
    if_instr = 16'h3641; if_pc = 16'h0302; ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({ex_valid, ex_pc, id_ready} !== {1'b1, 16'h0300, 1'b0}) begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%b want=1/0300/0", i, ex_valid, ex_pc, id_ready); end
      step();
    end
    ex_ready = 1'b1;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", id_ready); end
    step();
    if_valid = 1'b0;
    #1;
    total++; if (ex_pc !== 16'h0302) begin bad++; $display("FAIL bp_next_pc got=%h want=0302", ex_pc); end
  endtask

  task automatic test_flush();
    if_valid = 1'b1; if_instr = 16'hD000; if_pc = 16'h0400; flush = 1'b1;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", id_ready); end
    step();
    flush = 1'b0; if_valid = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", ex_valid); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_jal_dropped got=%b want=0", ex_valid); end
  endtask

  task automatic test_halt_pend_flush();
    if_valid = 1'b1; if_instr = 16'hF000; if_pc = 16'h0500;
    step();
    if_valid = 1'b0; ex_ready = 1'b0;
    #1;
    total++; if ({ex_valid, ex_ctrl} !== {1'b1, 18'h00004}) begin bad++; $display("FAIL hlt_bundle got=%b/%h want=1/00004", ex_valid, ex_ctrl); end
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL hpend_ready got=%b want=0", id_ready); end
    flush = 1'b1;
    step();
    flush = 1'b0; ex_ready = 1'b1;
    #1;
    total++; if ({ex_valid, id_ready, halted} !== 3'b010) begin bad++; $display("FAIL hpend_flush got=%b want=010", {ex_valid, id_ready, halted}); end
  endtask

  task automatic test_halt();
    if_valid = 1'b1; if_instr = 16'hF000; if_pc = 16'h0600;
    step();
    if_valid = 1'b0;
    #1;
    total++; if ({id_ready, halted} !== 2'b00) begin bad++; $display("FAIL halt_pend got=%b want=00", {id_ready, halted}); end
    step();
    total++; if ({halted, ex_valid, id_ready} !== 3'b100) begin bad++; $display("FAIL halt_retire got=%b want=100", {halted, ex_valid, id_ready}); end
    if_valid = 1'b1; if_instr = 16'h3312;
    step();
    total++; if ({ex_valid, halted} !== 2'b01) begin bad++; $display("FAIL halt_sticky got=%b want=01", {ex_valid, halted}); end
    if_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    #3 rst_n = 1'b0;
    #1;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL arst_halted got=%b want=0", halted); end
    #1 rst_n = 1'b1;
    step();
    if_valid = 1'b1; if_instr = 16'h3312; if_pc = 16'h0700;
    step();
    if_valid = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b want=1", ex_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({ex_valid, ex_ctrl, ex_pc} !== 35'h0) begin bad++; $display("FAIL arst_clear got=%b/%h/%h want=0/0/0", ex_valid, ex_ctrl, ex_pc); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_flush_retire();
    if_valid = 1'b1; if_instr = 16'hF000; if_pc = 16'h0800;
    step();
    if_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    total++; if ({halted, id_ready} !== 2'b10) begin bad++; $display("FAIL flush_retire got=%b want=10", {halted, id_ready}); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_add_dont_en();
    test_shift();
    test_load_use();
    test_backpressure();
    test_flush();
    test_halt_pend_flush();
    test_halt();
    test_async_reset();
    test_flush_retire();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
